// File: rtl/usb_cdc_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_cdc_buf_pkg
// Brief    : Shared types and width helpers for the USB CDC stream buffer.
// Revision : 1.0
// ============================================================================
package usb_cdc_buf_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } agg_state_t;

    localparam int c_DEF_DEPTH   = 16;
    localparam int c_DEF_TIMEOUT = 480;
    localparam int c_DEF_LVL_W   = $clog2(c_DEF_DEPTH) + 1;
    localparam int c_DEF_TMR_W   = $clog2(c_DEF_TIMEOUT + 1);

    // Level counters need one extra bit so a full FIFO is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int tmr_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_cdc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usb_cdc_sync_fifo
// Brief    : Single-clock FIFO with synchronous flush and fill-level output.
// Revision : 1.0
// ============================================================================
module usb_cdc_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = (c_AW + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Pointers carry a wrap bit: same index, different lap means full.
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/usb_cdc_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : usb_cdc_stream_buffer
// Brief    : IN/OUT stream FIFOs between application and USB CDC core; the IN
//            path optionally aggregates into bursts (USB_CDC_BUF_AGGREGATE_EN).
// Revision : 1.0
// ============================================================================
module usb_cdc_stream_buffer
    import usb_cdc_buf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int PKT_SIZE = 8,
    parameter int TIMEOUT  = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   configured_i,
    input  logic [DATA_W-1:0]      app_in_data,
    input  logic                   app_in_valid,
    output logic                   app_in_ready,
    output logic [DATA_W-1:0]      usb_in_data,
    output logic                   usb_in_valid,
    input  logic                   usb_in_ready,
    input  logic [DATA_W-1:0]      usb_out_data,
    input  logic                   usb_out_valid,
    output logic                   usb_out_ready,
    output logic [DATA_W-1:0]      app_out_data,
    output logic                   app_out_valid,
    input  logic                   app_out_ready,
    output logic [$clog2(DEPTH):0] in_level_o,
    output logic [$clog2(DEPTH):0] out_level_o,
    output logic [7:0]             drop_cnt_o
);

    localparam int c_LVL_W = lvl_w(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PKT_SIZE < 1 ||
        PKT_SIZE > DEPTH || TIMEOUT < 1) begin : g_bad_cfg
        $error("usb_cdc_stream_buffer: illegal parameter set");
    end

    logic w_flush;
    logic w_in_full, w_in_empty, w_in_push, w_in_pop;
    logic w_out_full, w_out_empty, w_out_push, w_out_pop;
    logic r_cfg_d;
    logic [7:0] r_drop_cnt;

    // Unconfigured: both FIFOs are held empty and everything offered is eaten.
    assign w_flush       = ~configured_i;
    assign app_in_ready  = rst_n & (w_flush | ~w_in_full);
    assign usb_out_ready = rst_n & (w_flush | ~w_out_full);
    assign w_in_push     = app_in_valid & app_in_ready & configured_i;
    assign w_in_pop      = usb_in_valid & usb_in_ready;
    assign w_out_push    = usb_out_valid & usb_out_ready & configured_i;
    assign app_out_valid = configured_i & ~w_out_empty;
    assign w_out_pop     = app_out_valid & app_out_ready;
    assign drop_cnt_o    = r_drop_cnt;

    usb_cdc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_in_push),
        .i_data  (app_in_data),
        .i_pop   (w_in_pop),
        .o_data  (usb_in_data),
        .o_full  (w_in_full),
        .o_empty (w_in_empty),
        .o_level (in_level_o)
    );

    usb_cdc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_out_push),
        .i_data  (usb_out_data),
        .i_pop   (w_out_pop),
        .o_data  (app_out_data),
        .o_full  (w_out_full),
        .o_empty (w_out_empty),
        .o_level (out_level_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_d    <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_cfg_d <= configured_i;
            if (configured_i && !r_cfg_d)
                r_drop_cnt <= 8'd0;
            else if (!configured_i && app_in_valid && app_in_ready && r_drop_cnt != 8'hFF)
                r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

`ifdef USB_CDC_BUF_AGGREGATE_EN
    localparam int                 c_TMR_W   = tmr_w(TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_TIMEOUT = c_TMR_W'(TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE = c_TMR_W'(1);
    localparam logic [c_LVL_W-1:0] c_PKT     = c_LVL_W'(PKT_SIZE);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);

    agg_state_t         r_state, w_state_nxt;
    logic [c_LVL_W-1:0] r_burst, w_burst_nxt;
    logic [c_TMR_W-1:0] r_timer, w_timer_nxt;

    assign usb_in_valid = configured_i & ~w_in_empty & (r_state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_burst <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        w_timer_nxt = r_timer;
        case (r_state)
            ACCUM: begin
                if (w_in_push || in_level_o == '0)
                    w_timer_nxt = '0;
                else if (r_timer != c_TIMEOUT)
                    w_timer_nxt = r_timer + c_TMR_ONE;
                if (in_level_o >= c_PKT || (r_timer == c_TIMEOUT && in_level_o != '0)) begin
                    w_state_nxt = DRAIN;
                    w_burst_nxt = (in_level_o >= c_PKT) ? c_PKT : in_level_o;
                    w_timer_nxt = '0;
                end
            end
            DRAIN: begin
                // Burst length is frozen on entry; late pushes wait for the next one.
                if (w_in_pop) begin
                    w_burst_nxt = r_burst - c_LVL_ONE;
                    if (r_burst == c_LVL_ONE) begin
                        w_state_nxt = ACCUM;
                        w_timer_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (!configured_i) begin
            w_state_nxt = ACCUM;
            w_burst_nxt = '0;
            w_timer_nxt = '0;
        end
    end
`else
    assign usb_in_valid = configured_i & ~w_in_empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_cdc_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_cdc_stream_buffer
// Brief    : Scoreboard bench for usb_cdc_stream_buffer (both build variants).
// Revision : 1.0
// ============================================================================
module tb_usb_cdc_stream_buffer;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int PKT     = 8;
    localparam int TIMEOUT = 480;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              configured = 1'b1;
    logic [DATA_W-1:0] app_in_data = '0;
    logic              app_in_valid = 1'b0;
    logic              app_in_ready;
    logic [DATA_W-1:0] usb_in_data;
    logic              usb_in_valid;
    logic              usb_in_ready = 1'b1;
    logic [DATA_W-1:0] usb_out_data = '0;
    logic              usb_out_valid = 1'b0;
    logic              usb_out_ready;
    logic [DATA_W-1:0] app_out_data;
    logic              app_out_valid;
    logic              app_out_ready = 1'b1;
    logic [LW-1:0]     in_level_o;
    logic [LW-1:0]     out_level_o;
    logic [7:0]        drop_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_in_cnt = 0;
    logic [DATA_W-1:0] exp_in[$];
    logic [DATA_W-1:0] exp_out[$];

    always #5 clk = ~clk;

    usb_cdc_stream_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PKT_SIZE(PKT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .configured_i  (configured),
        .app_in_data   (app_in_data),
        .app_in_valid  (app_in_valid),
        .app_in_ready  (app_in_ready),
        .usb_in_data   (usb_in_data),
        .usb_in_valid  (usb_in_valid),
        .usb_in_ready  (usb_in_ready),
        .usb_out_data  (usb_out_data),
        .usb_out_valid (usb_out_valid),
        .usb_out_ready (usb_out_ready),
        .app_out_data  (app_out_data),
        .app_out_valid (app_out_valid),
        .app_out_ready (app_out_ready),
        .in_level_o    (in_level_o),
        .out_level_o   (out_level_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (usb_in_valid && usb_in_ready) begin
                pop_in_cnt++;
                if (exp_in.size() == 0) fail_now("usb_in_unexpected_word");
                else chk("usb_in_data", 32'(usb_in_data), 32'(exp_in.pop_front()));
            end
            if (app_out_valid && app_out_ready) begin
                if (exp_out.size() == 0) fail_now("app_out_unexpected_word");
                else chk("app_out_data", 32'(app_out_data), 32'(exp_out.pop_front()));
            end
            if (!configured) begin
                chk("usb_in_valid_unconfigured", 32'(usb_in_valid), 32'd0);
            end
        end
    end

    task automatic push_in(input logic [DATA_W-1:0] d);
        bit acc;
        int n;
        app_in_data  = d;
        app_in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = app_in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) fail_now("push_in_timeout");
        else if (configured) exp_in.push_back(d);
        app_in_valid = 1'b0;
    endtask

    task automatic push_out(input logic [DATA_W-1:0] d);
        bit acc;
        int n;
        usb_out_data  = d;
        usb_out_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = usb_out_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) fail_now("push_out_timeout");
        else if (configured) exp_out.push_back(d);
        usb_out_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int max_cyc);
        int n = 0;
        while ((exp_in.size() != 0 || in_level_o != '0 || exp_out.size() != 0 ||
                out_level_o != '0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_in.size() == 0 && in_level_o == '0 &&
                      exp_out.size() == 0 && out_level_o == '0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_app_in_ready", 32'(app_in_ready), 32'd0);
        chk("rst_usb_out_ready", 32'(usb_out_ready), 32'd0);
        chk("rst_usb_in_valid", 32'(usb_in_valid), 32'd0);
        chk("rst_app_out_valid", 32'(app_out_valid), 32'd0);
        chk("rst_in_level", 32'(in_level_o), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_app_in_ready", 32'(app_in_ready), 32'd1);
        chk("post_rst_usb_out_ready", 32'(usb_out_ready), 32'd1);
        tick();

        // Single word both directions
        push_in(8'hA5);
        chk("a5_in_level", 32'(in_level_o), 32'd1);
        chk("a5_in_head", 32'(usb_in_data), 32'hA5);
`ifndef USB_CDC_BUF_AGGREGATE_EN
        chk("a5_in_valid", 32'(usb_in_valid), 32'd1);
        tick();
        chk("a5_in_level_after", 32'(in_level_o), 32'd0);
`endif
        push_out(8'hA5);
        chk("a5_out_valid", 32'(app_out_valid), 32'd1);
        chk("a5_out_data", 32'(app_out_data), 32'hA5);
        tick();
        chk("a5_out_level_after", 32'(out_level_o), 32'd0);
        wait_drained("a5_drained", 1000);

        // Fill to full, attempt a 17th word, then drain in order
        usb_in_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_in(8'(i));
        chk("full_app_in_ready", 32'(app_in_ready), 32'd0);
        chk("full_in_level", 32'(in_level_o), 32'd16);
        app_in_data  = 8'd16;
        app_in_valid = 1'b1;
        repeat (3) tick();
        app_in_valid = 1'b0;
        chk("full_level_hold", 32'(in_level_o), 32'd16);
        chk("full_head_stable", 32'(usb_in_data), 32'd0);
        usb_in_ready = 1'b1;
        wait_drained("full_drained", 200);

        // Steady state at level 8 with simultaneous push/pop, crossing wrap
        usb_in_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_in(8'(8'd100 + 8'(i)));
        usb_in_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_in(8'(8'd108 + 8'(i)));
`ifndef USB_CDC_BUF_AGGREGATE_EN
            chk("steady_level8", 32'(in_level_o), 32'd8);
`endif
        end
        wait_drained("steady_drained", 1000);

        // OUT path fill with back-pressure
        app_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_out(8'(8'hC0 + 8'(i)));
        chk("out_full_ready", 32'(usb_out_ready), 32'd0);
        chk("out_full_level", 32'(out_level_o), 32'd16);
        app_out_ready = 1'b1;
        wait_drained("out_drained", 200);

        // Configuration drop flushes queued words
        usb_in_ready  = 1'b0;
        app_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_in(8'(8'h50 + 8'(i)));
        for (int i = 0; i < 2; i++) push_out(8'(8'h60 + 8'(i)));
        configured = 1'b0;
        exp_in.delete();
        exp_out.delete();
        tick();
        chk("flush_in_level", 32'(in_level_o), 32'd0);
        chk("flush_out_level", 32'(out_level_o), 32'd0);
        usb_in_ready  = 1'b1;
        app_out_ready = 1'b1;

        // Unconfigured: everything accepted, drop count saturates
        for (int i = 0; i < 200; i++) push_in(8'(i));
        chk("drop_cnt_200", 32'(drop_cnt_o), 32'd200);
        for (int i = 0; i < 100; i++) push_in(8'(i));
        chk("drop_cnt_sat", 32'(drop_cnt_o), 32'd255);
        chk("uncfg_in_level", 32'(in_level_o), 32'd0);
        for (int i = 0; i < 5; i++) push_out(8'(i));
        chk("drop_cnt_out_uncounted", 32'(drop_cnt_o), 32'd255);
        chk("uncfg_app_out_valid", 32'(app_out_valid), 32'd0);
        configured = 1'b1;
        tick();
        chk("drop_cnt_restart", 32'(drop_cnt_o), 32'd0);

`ifdef USB_CDC_BUF_AGGREGATE_EN
        begin
            int base;
            int i;
            // Three words then idle: flushed by timeout
            base = pop_in_cnt;
            for (int k = 0; k < 3; k++) push_in(8'(8'h70 + 8'(k)));
            i = 0;
            while (i < 1000) begin
                @(negedge clk);
                if (usb_in_valid) break;
                @(posedge clk);
                #1;
                i++;
            end
            chk("timeout_window", 32'(i >= TIMEOUT && i <= TIMEOUT + 2), 32'd1);
            wait_drained("timeout_drained", 50);
            tick();
            chk("timeout_pop_count", 32'(pop_in_cnt - base), 32'd3);
            chk("timeout_valid_low", 32'(usb_in_valid), 32'd0);

            // Ten back-to-back: burst of 8, remaining 2 after timeout
            base = pop_in_cnt;
            for (int k = 0; k < 10; k++) push_in(8'(8'h30 + 8'(k)));
            repeat (20) tick();
            chk("burst8_pops", 32'(pop_in_cnt - base), 32'd8);
            chk("burst8_level", 32'(in_level_o), 32'd2);
            chk("burst8_accum", 32'(usb_in_valid), 32'd0);
            wait_drained("burst_tail_drained", 700);
            chk("burst_total_pops", 32'(pop_in_cnt - base), 32'd10);
        end
`endif

        // Reset mid-burst abandons queued data
        usb_in_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_in(8'(8'h90 + 8'(i)));
        rst_n = 1'b0;
        exp_in.delete();
        #1;
        chk("midrst_valid", 32'(usb_in_valid), 32'd0);
        chk("midrst_level", 32'(in_level_o), 32'd0);
        chk("midrst_ready", 32'(app_in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        usb_in_ready = 1'b1;
        repeat (10) tick();
        chk("postrst_valid", 32'(usb_in_valid), 32'd0);
        chk("postrst_level", 32'(in_level_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_cdc_stream_buffer.md
USB_CDC_STREAM_BUFFER -- requirements
Module: usb_cdc_stream_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: stream byte/word width.
REQ-002 SHALL have parameter DEPTH, default 16: entries per FIFO; power of two, minimum 4.
REQ-003 SHALL have parameter PKT_SIZE, default 8: IN aggregation threshold, 1..DEPTH.
REQ-004 SHALL have parameter TIMEOUT, default 480: IN idle-flush timeout in clk cycles, at least 1.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk input 1, the single clock; rst_n input 1, async reset.
REQ-006 SHALL have the configured_i interface: input, 1 bit, USB device configured.
REQ-007 SHALL have the app-to-host input stream: app_in_data input DATA_W; app_in_valid input 1; app_in_ready output 1.
REQ-008 SHALL have the app-to-host output stream towards the CDC core: usb_in_data output DATA_W; usb_in_valid output 1; usb_in_ready input 1.
REQ-009 SHALL have the host-to-app input stream from the CDC core: usb_out_data input DATA_W; usb_out_valid input 1; usb_out_ready output 1.
REQ-010 SHALL have the host-to-app output stream: app_out_data output DATA_W; app_out_valid output 1; app_out_ready input 1.
REQ-011 SHALL have level and drop outputs: in_level_o output $clog2(DEPTH)+1; out_level_o output $clog2(DEPTH)+1; drop_cnt_o output 8, saturating dropped-word count.

Function
REQ-012 SHALL transfer a word only on a cycle where both valid and ready are high.
REQ-013 SHALL contain two independent FIFOs: IN (app to usb_in) and OUT (usb_out to app).
REQ-014 SHALL drive ready = !full and, in FIFO pass mode, valid = !empty; no full-bypass or empty-bypass.
REQ-015 SHALL present a word on the output side in the cycle after the cycle it is written: first-word latency of 1.
REQ-016 SHALL keep level unchanged on simultaneous push and pop, and keep data order intact across pointer wrap-around.
REQ-017 SHALL hold output data stable while valid=1 and ready=0.
REQ-018 While configured_i=0, SHALL force both FIFOs empty, force app_in_ready=1 and usb_out_ready=1, and discard all accepted words.
REQ-019 While configured_i=0, SHALL increment drop_cnt_o by one per accepted app_in word, saturating at 255; usb_out words are discarded uncounted.
REQ-020 SHALL restart drop_cnt_o at 0 on a rising edge of configured_i.

Reset
REQ-021 Asynchronous reset SHALL apply: both FIFOs empty, levels 0, drop_cnt_o 0, all valid outputs 0, FSM in ACCUM, timer 0.
REQ-022 During reset, the ready outputs SHALL be 0.
REQ-023 In the first cycle after reset, ready SHALL follow REQ-014 and REQ-018.
REQ-024 Any reset mid-burst SHALL abandon the burst with no further output.

Configuration
REQ-025 The macro USB_CDC_BUF_AGGREGATE_EN SHALL control IN-path aggregation.
REQ-026 If USB_CDC_BUF_AGGREGATE_EN is undefined, the IN path SHALL be plain FIFO per REQ-014, with no FSM or timer logic.
REQ-027 If USB_CDC_BUF_AGGREGATE_EN is defined, the IN path SHALL gate usb_in_valid with an FSM of two states, ACCUM and DRAIN.
REQ-028 In ACCUM, usb_in_valid SHALL be 0.
REQ-029 In ACCUM, the idle timer SHALL clear on each app_in push or when in_level_o=0, and otherwise increment.
REQ-030 The FSM SHALL move from ACCUM to DRAIN when in_level_o >= PKT_SIZE, or when the timer reaches TIMEOUT with in_level_o > 0.
REQ-031 On entering DRAIN, the FSM SHALL latch burst = min(in_level_o, PKT_SIZE).
REQ-032 In DRAIN, usb_in_valid SHALL be 1; each pop SHALL decrement burst; after the pop that takes burst to 0, the FSM SHALL return to ACCUM and clear the timer.
REQ-033 Pushes during DRAIN SHALL be accepted but SHALL NOT extend the burst.
REQ-034 A configured_i drop SHALL force the FSM to ACCUM.

Structure
REQ-035 Package usb_cdc_buf_pkg SHALL hold the FSM state enum (ACCUM, DRAIN) and the width localparams derived from DEPTH and TIMEOUT.
REQ-036 Sub-module usb_cdc_sync_fifo SHALL be a parametrised DATA_W/DEPTH FIFO with flush input and level output, instantiated twice.

Verification
REQ-037 Bench SHALL cover: reset, configured_i=1, push 0xA5 -> app side reads 0xA5 one cycle later; in_level_o returns to 0.
REQ-038 Bench SHALL cover: DEPTH=16, usb_in_ready=0, push 17 words -> app_in_ready=0 after the 16th; words 0..15 drained in order.
REQ-039 Bench SHALL cover: simultaneous push and pop at level 8 for 40 cycles -> level stays 8; order preserved across wrap.
REQ-040 Bench SHALL cover: configured_i=0, push 300 words -> all accepted, drop_cnt_o=255, usb_in_valid never 1.
REQ-041 With USB_CDC_BUF_AGGREGATE_EN defined, bench SHALL cover: push 3 words then idle -> usb_in_valid rises after 480 idle cycles, exactly 3 words drained.
REQ-042 With USB_CDC_BUF_AGGREGATE_EN defined, bench SHALL cover: push 10 words back-to-back -> burst of 8, return to ACCUM; the remaining 2 words leave after timeout.
